id_ex_reg: RTL and testbench



---
 rtl/id_ex_reg.sv | 128 ++++++++++++
 tb/tb_id_ex_reg.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register: captures decode-stage data and control on each rising edge.
// Define ID_EX_HAZARD_CTRL_EN to add Stall/Flush hazard-control inputs.
module id_ex_reg #(
  parameter int DATA_W  = 32,
  parameter int ALUOP_W = 32,
  parameter int REG_W   = 5
) (
  input  logic               Clk,
  input  logic               Reset,
`ifdef ID_EX_HAZARD_CTRL_EN
  input  logic               Stall,
  input  logic               Flush,
`endif
  input  logic [DATA_W-1:0]  PCAddIn,
  input  logic [DATA_W-1:0]  RD1In,
  input  logic [DATA_W-1:0]  RD2In,
  input  logic [DATA_W-1:0]  SignExtendIn,
  input  logic [ALUOP_W-1:0] ALUOpIn,
  input  logic [REG_W-1:0]   Instr106In,
  input  logic [REG_W-1:0]   Instr2016In,
  input  logic [REG_W-1:0]   Instr1511In,
  input  logic               MsubIn,
  input  logic               MaddIn,
  input  logic               HiLoWriteIn,
  input  logic               RegWriteIn,
  input  logic               MoveNotZeroIn,
  input  logic               DontMoveIn,
  input  logic               HiOrLoIn,
  input  logic               MemToRegIn,
  input  logic               HiLoToRegIn,
  input  logic               MemWriteIn,
  input  logic               BranchIn,
  input  logic               MemReadIn,
  input  logic               RegDestIn,
  input  logic               ALUSrcIn,
  output logic [DATA_W-1:0]  PCAddOut,
  output logic [DATA_W-1:0]  RD1Out,
  output logic [DATA_W-1:0]  RD2Out,
  output logic [DATA_W-1:0]  SignExtendOut,
  output logic [ALUOP_W-1:0] ALUOpOut,
  output logic [REG_W-1:0]   Instr106Out,
  output logic [REG_W-1:0]   Instr2016Out,
  output logic [REG_W-1:0]   Instr1511Out,
  output logic               MsubOut,
  output logic               MaddOut,
  output logic               HiLoWriteOut,
  output logic               RegWriteOut,
  output logic               MoveNotZeroOut,
  output logic               DontMoveOut,
  output logic               HiOrLoOut,
  output logic               MemToRegOut,
  output logic               HiLoToRegOut,
  output logic               MemWriteOut,
  output logic               BranchOut,
  output logic               MemReadOut,
  output logic               RegDestOut,
  output logic               ALUSrcOut
);

  logic loadEn;
  logic clearCtrl;

  // Flush outranks Stall: a flushed edge always loads, with control forced to a bubble.
`ifdef ID_EX_HAZARD_CTRL_EN
  assign loadEn    = Flush | ~Stall;
  assign clearCtrl = Flush;
`else
  assign loadEn    = 1'b1;
  assign clearCtrl = 1'b0;
`endif

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      PCAddOut      <= '0;
      RD1Out        <= '0;
      RD2Out        <= '0;
      SignExtendOut <= '0;
      Instr106Out   <= '0;
      Instr2016Out  <= '0;
      Instr1511Out  <= '0;
    end else if (loadEn) begin
      PCAddOut      <= PCAddIn;
      RD1Out        <= RD1In;
      RD2Out        <= RD2In;
      SignExtendOut <= SignExtendIn;
      Instr106Out   <= Instr106In;
      Instr2016Out  <= Instr2016In;
      Instr1511Out  <= Instr1511In;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset || (loadEn && clearCtrl)) begin
      ALUOpOut       <= '0;
      MsubOut        <= 1'b0;
      MaddOut        <= 1'b0;
      HiLoWriteOut   <= 1'b0;
      RegWriteOut    <= 1'b0;
      MoveNotZeroOut <= 1'b0;
      DontMoveOut    <= 1'b0;
      HiOrLoOut      <= 1'b0;
      MemToRegOut    <= 1'b0;
      HiLoToRegOut   <= 1'b0;
      MemWriteOut    <= 1'b0;
      BranchOut      <= 1'b0;
      MemReadOut     <= 1'b0;
      RegDestOut     <= 1'b0;
      ALUSrcOut      <= 1'b0;
    end else if (loadEn) begin
      ALUOpOut       <= ALUOpIn;
      MsubOut        <= MsubIn;
      MaddOut        <= MaddIn;
      HiLoWriteOut   <= HiLoWriteIn;
      RegWriteOut    <= RegWriteIn;
      MoveNotZeroOut <= MoveNotZeroIn;
      DontMoveOut    <= DontMoveIn;
      HiOrLoOut      <= HiOrLoIn;
      MemToRegOut    <= MemToRegIn;
      HiLoToRegOut   <= HiLoToRegIn;
      MemWriteOut    <= MemWriteIn;
      BranchOut      <= BranchIn;
      MemReadOut     <= MemReadIn;
      RegDestOut     <= RegDestIn;
      ALUSrcOut      <= ALUSrcIn;
    end
  end

endmodule

// File: tb/tb_id_ex_reg.sv
// Scoreboard bench for id_ex_reg; all fields are packed into one vector (controls in the LSBs).
// Hazard-control tests are built when ID_EX_HAZARD_CTRL_EN is defined.
module tb_id_ex_reg;

  localparam int VW = 189;

  logic          Clk;
  logic          Reset;
  logic          stall;
  logic          flush;
  logic [VW-1:0] inVec;
  wire  [VW-1:0] outVec;

  logic [VW-1:0] expQ[$];
  logic [VW-1:0] modelState;
  int            checks;
  int            errors;

  id_ex_reg dut (
    .Clk(Clk),
    .Reset(Reset),
`ifdef ID_EX_HAZARD_CTRL_EN
    .Stall(stall),
    .Flush(flush),
`endif
    .PCAddIn(inVec[188:157]),
    .RD1In(inVec[156:125]),
    .RD2In(inVec[124:93]),
    .SignExtendIn(inVec[92:61]),
    .ALUOpIn(inVec[60:29]),
    .Instr106In(inVec[28:24]),
    .Instr2016In(inVec[23:19]),
    .Instr1511In(inVec[18:14]),
    .MsubIn(inVec[13]),
    .MaddIn(inVec[12]),
    .HiLoWriteIn(inVec[11]),
    .RegWriteIn(inVec[10]),
    .MoveNotZeroIn(inVec[9]),
    .DontMoveIn(inVec[8]),
    .HiOrLoIn(inVec[7]),
    .MemToRegIn(inVec[6]),
    .HiLoToRegIn(inVec[5]),
    .MemWriteIn(inVec[4]),
    .BranchIn(inVec[3]),
    .MemReadIn(inVec[2]),
    .RegDestIn(inVec[1]),
    .ALUSrcIn(inVec[0]),
    .PCAddOut(outVec[188:157]),
    .RD1Out(outVec[156:125]),
    .RD2Out(outVec[124:93]),
    .SignExtendOut(outVec[92:61]),
    .ALUOpOut(outVec[60:29]),
    .Instr106Out(outVec[28:24]),
    .Instr2016Out(outVec[23:19]),
    .Instr1511Out(outVec[18:14]),
    .MsubOut(outVec[13]),
    .MaddOut(outVec[12]),
    .HiLoWriteOut(outVec[11]),
    .RegWriteOut(outVec[10]),
    .MoveNotZeroOut(outVec[9]),
    .DontMoveOut(outVec[8]),
    .HiOrLoOut(outVec[7]),
    .MemToRegOut(outVec[6]),
    .HiLoToRegOut(outVec[5]),
    .MemWriteOut(outVec[4]),
    .BranchOut(outVec[3]),
    .MemReadOut(outVec[2]),
    .RegDestOut(outVec[1]),
    .ALUSrcOut(outVec[0])
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Reference behaviour of one rising edge with reset low.
  function automatic logic [VW-1:0] modelNext(input logic [VW-1:0] prev, input logic [VW-1:0] in,
                                              input logic st, input logic fl);
    logic [VW-1:0] r;
    r = in;
    if (fl) begin
      r[60:29] = '0;
      r[13:0]  = '0;
    end else if (st) begin
      r = prev;
    end
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [VW-1:0] observed, input logic [VW-1:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic pushExpected();
    modelState = modelNext(modelState, inVec, stall, flush);
    expQ.push_back(modelState);
  endtask

  task automatic popCheck(input string tag);
    logic [VW-1:0] e;
    if (expQ.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s: scoreboard empty, got %h expected a queued value", tag, outVec);
    end else begin
      e = expQ.pop_front();
      checkOutput(tag, outVec, e);
    end
  endtask

  // Drive one decode bundle, then compare at the negedge after the capturing edge.
  task automatic applyStimulus(input logic [VW-1:0] vec, input string tag);
    inVec = vec;
    pushExpected();
    @(posedge Clk);
    @(negedge Clk);
    popCheck(tag);
  endtask

  initial begin
    logic [VW-1:0] v;
    int lo;
    int w;
    checks = 0;
    errors = 0;
    stall  = 1'b0;
    flush  = 1'b0;
    Reset  = 1'b1;
    inVec  = '1;
    modelState = '0;

    repeat (3) @(posedge Clk);
    @(negedge Clk);
    checkOutput("resetAllOnesIn", outVec, '0);
    @(posedge Clk);
    #1 checkOutput("resetHeldAfterEdge", outVec, '0);
    @(negedge Clk);
    Reset = 1'b0;
    v = '1;
    applyStimulus(v, "firstLoadAllOnes");

    // Walk each of the 22 fields to all-ones with the rest at zero.
    lo = 0;
    for (int f = 0; f < 22; f++) begin
      w = (f < 14) ? 1 : (f < 17) ? 5 : 32;
      v = '0;
      for (int b = 0; b < w; b++) v[lo + b] = 1'b1;
      applyStimulus(v, $sformatf("walkField%0d", f));
      lo += w;
    end

    for (int k = 1; k <= 3; k++) begin
      v = '0;
      v[188:157] = 32'(4 * k);
      applyStimulus(v, $sformatf("pipePC%0d", 4 * k));
    end

    for (int k = 0; k < 4; k++) begin
      v = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      applyStimulus(v, $sformatf("random%0d", k));
    end

    v = '0;
    v[156:125] = 32'h12345678;
    applyStimulus(v, "rd1Load");
    #2 Reset = 1'b1;
    #1 checkOutput("asyncResetMidCycle", outVec, '0);
    modelState = '0;
    @(posedge Clk);
    #1 checkOutput("resetHoldsThroughEdge", outVec, '0);
    @(negedge Clk);
    Reset = 1'b0;
    applyStimulus(v, "reloadAfterReset");

    v = '0;
    v[60:29] = 32'd7;
    applyStimulus(v, "aluOpSeven");
    inVec = '0;
    pushExpected();
    @(posedge Clk);
    #1 inVec[60:29] = 32'd5;
    @(negedge Clk);
    popCheck("aluOpMidCycleHold");
    pushExpected();
    @(posedge Clk);
    @(negedge Clk);
    popCheck("aluOpFive");

`ifdef ID_EX_HAZARD_CTRL_EN
    v = '1;
    applyStimulus(v, "preStallLoad");
    stall = 1'b1;
    v = '0;
    v[156:125] = 32'hDEADBEEF;
    applyStimulus(v, "stallHolds");
    checkOutput("stallHoldsAllOnes", outVec, {VW{1'b1}});
    stall = 1'b0;
    flush = 1'b1;
    v = '0;
    v[10] = 1'b1;
    v[156:125] = 32'h000000A5;
    applyStimulus(v, "flushBubble");
    checkOutput("flushRd1Kept", {157'b0, outVec[156:125]}, {157'b0, 32'h000000A5});
    stall = 1'b1;
    v = '1;
    applyStimulus(v, "flushOverStall");
    stall = 1'b0;
    flush = 1'b0;
    applyStimulus(v, "afterHazard");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
